// File: rtl/fetch_if_id_stage_if.sv
// Fetch-stage bus: hazard/redirect controls from ID and the hazard unit,
// the instruction-memory read port, and the IF/ID register seen by decode.
interface fetch_if_id_stage_if #(
   parameter int ADDR_W = 32
);
   logic              stall;
   logic              flush;
   logic              br_taken;
   logic              br_annul;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] npc;
   logic [31:0]       ifid_instr;
   logic [ADDR_W-1:0] ifid_pc;
   logic              ifid_valid;
   logic [31:0]       fetch_count;

   // Fetch stage side: consumes controls and the memory word, drives the rest.
   modport master (
      input  stall, flush, br_taken, br_annul, br_target, imem_rdata,
      output imem_addr, pc, npc, ifid_instr, ifid_pc, ifid_valid, fetch_count
   );

   // Surrounding pipeline side: hazard unit, ID, memory and decode.
   modport slave (
      output stall, flush, br_taken, br_annul, br_target, imem_rdata,
      input  imem_addr, pc, npc, ifid_instr, ifid_pc, ifid_valid, fetch_count
   );
endinterface

// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage: owns the PC/nPC pair, presents pc to instruction
// memory, follows delayed-branch redirects from ID, and loads the IF/ID
// register. Stall holds everything; flush and annul turn the slot into a NOP.
module fetch_if_id_stage #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [31:0]       NOP_WORD = 32'h0100_0000
) (
   input logic              clk,
   input logic              reset,
   fetch_if_id_stage_if.master bus
);

   // Next sequential address; wraps modulo 2^ADDR_W with no carry out.
   function automatic logic [ADDR_W-1:0] inc4(input logic [ADDR_W-1:0] a);
      return a + ADDR_W'(4);
   endfunction

   // Branch targets are word addresses; low two bits are discarded.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

   // Fetch-side state (PC pair) and IF/ID register contents.
   logic [ADDR_W-1:0] pc_p0;
   logic [ADDR_W-1:0] npc_p0;
   logic [31:0]       instr_p1;
   logic [ADDR_W-1:0] pc_p1;
   logic              vld_p1;
   logic [31:0]       fetch_count_p1;

   // Next-state values.
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] npc_nxt;
   logic [ADDR_W-1:0] redirect_pc;
   logic [31:0]       instr_nxt;
   logic [ADDR_W-1:0] pc_p1_nxt;
   logic              vld_nxt;
   logic              count_inc;

   assign redirect_pc = word_align(bus.br_target);

   // Resolve stall > flush > branch > sequential into next PC pair and IF/ID slot.
   always_comb begin
      pc_nxt    = pc_p0;
      npc_nxt   = npc_p0;
      instr_nxt = instr_p1;
      pc_p1_nxt = pc_p1;
      vld_nxt   = vld_p1;
      count_inc = 1'b0;
      if (!bus.stall) begin
         if (bus.br_taken) begin
            pc_nxt  = redirect_pc;
            npc_nxt = inc4(redirect_pc);
         end else begin
            pc_nxt  = npc_p0;
            npc_nxt = inc4(npc_p0);
         end
         // The word at pc is the delay slot when a branch sits in ID.
         pc_p1_nxt = pc_p0;
         if (bus.flush || (bus.br_taken && bus.br_annul)) begin
            vld_nxt   = 1'b0;
            instr_nxt = NOP_WORD;
         end else begin
            vld_nxt   = 1'b1;
            instr_nxt = bus.imem_rdata;
            count_inc = 1'b1;
         end
      end
   end

   // ---- IF -> IF/ID boundary: register PC pair, IF/ID slot and live-fetch count.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_p0          <= RESET_PC;
         npc_p0         <= inc4(RESET_PC);
         instr_p1       <= NOP_WORD;
         pc_p1          <= '0;
         vld_p1         <= 1'b0;
         fetch_count_p1 <= '0;
      end else begin
         pc_p0    <= pc_nxt;
         npc_p0   <= npc_nxt;
         instr_p1 <= instr_nxt;
         pc_p1    <= pc_p1_nxt;
         vld_p1   <= vld_nxt;
         if (count_inc) begin
            fetch_count_p1 <= fetch_count_p1 + 32'd1;
         end
      end
   end

   // Only imem_addr is combinational, and only from the pc register.
   assign bus.imem_addr   = pc_p0;
   assign bus.pc          = pc_p0;
   assign bus.npc         = npc_p0;
   assign bus.ifid_instr  = instr_p1;
   assign bus.ifid_pc     = pc_p1;
   assign bus.ifid_valid  = vld_p1;
   assign bus.fetch_count = fetch_count_p1;

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Bench for fetch_if_id_stage: directed scenarios followed by randomized
// control traffic, all compared against a transaction-level reference model.
module tb_fetch_if_id_stage;
   localparam logic [31:0] NOP = 32'h0100_0000;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   fetch_if_id_stage_if #(.ADDR_W(32)) bus ();

   fetch_if_id_stage #(
      .ADDR_W   (32),
      .RESET_PC (32'h0),
      .NOP_WORD (NOP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: a distinct scrambled word per address.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (32'hA000_0000 + (a >> 2)) ^ (a << 14);
   endfunction

   assign bus.imem_rdata = word_at(bus.imem_addr);

   // Reference model: architectural view of the fetch stage.
   logic [31:0] m_pc, m_instr, m_ifpc, m_count;
   logic        m_valid, m_ifpc_known;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_instr = NOP; m_ifpc = 32'h0; m_count = 0;
      m_valid = 1'b0; m_ifpc_known = 1'b1;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"},        bus.pc,         m_pc);
      chk({tag, ".npc"},       bus.npc,        m_pc + 32'd4);
      chk({tag, ".imem_addr"}, bus.imem_addr,  m_pc);
      chk({tag, ".valid"},     32'(bus.ifid_valid), 32'(m_valid));
      chk({tag, ".instr"},     bus.ifid_instr, m_instr);
      chk({tag, ".count"},     bus.fetch_count, m_count);
      if (m_ifpc_known) chk({tag, ".ifid_pc"}, bus.ifid_pc, m_ifpc);
   endtask

   // One clock edge with the given controls; model advanced alongside.
   task automatic step(input string tag, input logic rs, input logic st, input logic fl,
                       input logic bt, input logic ba, input logic [31:0] tgt);
      logic [31:0] fetched;
      reset = rs; bus.stall = st; bus.flush = fl;
      bus.br_taken = bt; bus.br_annul = ba; bus.br_target = tgt;
      fetched = word_at(m_pc);
      if (rs) begin
         model_reset();
      end else if (!st) begin
         if (fl) begin
            m_valid = 1'b0; m_instr = NOP; m_ifpc_known = 1'b0;
         end else begin
            m_ifpc = m_pc; m_ifpc_known = 1'b1;
            m_valid = !(bt && ba);
            m_instr = m_valid ? fetched : NOP;
            if (m_valid) m_count = m_count + 1;
         end
         m_pc = bt ? (tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, ".rst_pc"},    bus.pc,          32'h0);
      chk({tag, ".rst_npc"},   bus.npc,         32'h4);
      chk({tag, ".rst_instr"}, bus.ifid_instr,  NOP);
      chk({tag, ".rst_ifpc"},  bus.ifid_pc,     32'h0);
      chk({tag, ".rst_valid"}, 32'(bus.ifid_valid), 32'h0);
      chk({tag, ".rst_count"}, bus.fetch_count, 32'h0);
   endtask

   initial begin
      logic [31:0] pc_hold, cnt_hold;
      reset = 1'b1;
      bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0;
      bus.br_annul = 1'b0; bus.br_target = 32'h0;
      model_reset();

      // Reset, then four free-running fetches.
      step("reset", 1, 0, 0, 0, 0, 0);
      check_reset_values("reset");
      for (int i = 0; i < 4; i++) begin
         step("free", 0, 0, 0, 0, 0, 0);
         chk("free.ifid_pc_seq", bus.ifid_pc, 32'(i * 4));
      end
      chk("free.pc10",   bus.pc,          32'h10);
      chk("free.npc14",  bus.npc,         32'h14);
      chk("free.count4", bus.fetch_count, 32'd4);

      // Taken branch with a live delay slot at pc=8.
      step("rst2", 1, 0, 0, 0, 0, 0);
      step("seq", 0, 0, 0, 0, 0, 0);
      step("seq", 0, 0, 0, 0, 0, 0);
      step("br", 0, 0, 0, 1, 0, 32'h103);
      chk("br.ifid_pc", bus.ifid_pc, 32'h8);
      chk("br.valid",   32'(bus.ifid_valid), 32'h1);
      chk("br.pc",      bus.pc,  32'h100);
      chk("br.npc",     bus.npc, 32'h104);

      // Same branch with the delay slot annulled.
      step("rst3", 1, 0, 0, 0, 0, 0);
      step("seq", 0, 0, 0, 0, 0, 0);
      step("seq", 0, 0, 0, 0, 0, 0);
      cnt_hold = bus.fetch_count;
      step("annul", 0, 0, 0, 1, 1, 32'h103);
      chk("annul.valid", 32'(bus.ifid_valid), 32'h0);
      chk("annul.instr", bus.ifid_instr, NOP);
      chk("annul.count", bus.fetch_count, cnt_hold);
      chk("annul.pc",    bus.pc, 32'h100);

      // Annul without taken is inert.
      step("annul_only", 0, 0, 0, 0, 1, 32'h500);
      chk("annul_only.valid", 32'(bus.ifid_valid), 32'h1);

      // Stall for three cycles with a pending branch, then release it.
      step("seq", 0, 0, 0, 0, 0, 0);
      pc_hold = bus.pc; cnt_hold = bus.fetch_count;
      for (int i = 0; i < 3; i++) begin
         step("stall", 0, 1, 1, 1, 0, 32'h200);
         chk("stall.pc_hold",  bus.pc, pc_hold);
         chk("stall.cnt_hold", bus.fetch_count, cnt_hold);
      end
      step("unstall", 0, 0, 0, 1, 0, 32'h200);
      chk("unstall.pc", bus.pc, 32'h200);
      chk("unstall.ifid_pc", bus.ifid_pc, pc_hold);

      // Flush together with a branch at pc=0x20.
      step("to20", 0, 0, 0, 1, 0, 32'h20);
      step("flush_br", 0, 0, 1, 1, 0, 32'h40);
      chk("flush_br.valid", 32'(bus.ifid_valid), 32'h0);
      chk("flush_br.pc",    bus.pc,  32'h40);
      chk("flush_br.npc",   bus.npc, 32'h44);

      // Address wrap at the top of memory, then mid-run reset.
      step("to_top", 0, 0, 0, 1, 0, 32'hFFFF_FFF8);
      step("wrap1", 0, 0, 0, 0, 0, 0);
      chk("wrap1.npc", bus.npc, 32'h0);
      step("wrap2", 0, 0, 0, 0, 0, 0);
      chk("wrap2.pc", bus.pc, 32'h0);
      step("midreset", 1, 0, 1, 1, 1, 32'h1234);
      check_reset_values("midreset");

      // Randomized control traffic including occasional resets.
      for (int i = 0; i < 400; i++) begin
         logic rs, st, fl, bt, ba;
         rs = ($urandom_range(0, 49) == 0);
         st = ($urandom_range(0, 4) == 0);
         fl = ($urandom_range(0, 7) == 0);
         bt = ($urandom_range(0, 4) == 0);
         ba = ($urandom_range(0, 2) == 0);
         step("rand", rs, st, fl, bt, ba, $urandom());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end
endmodule
